// File: rtl/serial_port_tx_gen.sv
// serial_port_tx_gen
//   Buffered serial transmitter. Host words are queued in a FIFO and sent
//   LSB-first on tx. Each frame is a start bit, DATA_BITS data bits, an
//   optional parity bit, and one or two stop bits. Bit timing is taken from
//   the shared baud generator: tick = (phase == 0) && change.
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   phase, change baud phase / phase-change strobe
//   parity_en     1 = append parity bit
//   parity_odd    1 = odd parity, 0 = even
//   two_stop      1 = two stop bits
//   tx_data/tx_dv word to queue / write strobe
//   full, empty   FIFO status
//   overflow      one-cycle pulse after a write was dropped on full
//   level         FIFO occupancy 0..FIFO_DEPTH
//   busy          frame in progress
//   tx            serial line
module serial_port_tx_gen #(
  parameter  int DATA_BITS  = 8,
  parameter  int FIFO_DEPTH = 32,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           phase,
  input  logic                 change,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_dv,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [FIFO_AW:0]     level,
  output logic                 busy,
  output logic                 tx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS);
  localparam logic [FIFO_AW:0] DEPTH_LV = (FIFO_AW+1)'(FIFO_DEPTH);

  logic tick;
  assign tick = (phase == 2'd0) && change;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q;
  logic                 overflow_q;
  logic                 wr_en;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign full     = (count_q == DEPTH_LV);
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign overflow = overflow_q;
  assign head     = mem_q[rd_ptr_q];
  // full is the registered occupancy, so a pop in the same cycle does not
  // make room for a write that arrives while full.
  assign wr_en    = tx_dv && !full;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= tx_dv && full;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM; the state names the bit currently on the line.
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 pen_q, pen_d;
  logic                 two_stop_q, two_stop_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  assign tx   = tx_q;
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      pen_q      <= 1'b0;
      two_stop_q <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      pen_q      <= pen_d;
      two_stop_q <= two_stop_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    pen_d      = pen_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tick && !empty) begin
          pop        = 1'b1;
          sh_d       = head;
          pen_d      = parity_en;
          two_stop_d = two_stop;
          par_bit_d  = (^head) ^ parity_odd;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          // The data word is shifted out so the line bit is always sh_q[0].
          tx_d      = sh_q[0];
          sh_d      = sh_q >> 1;
          bit_cnt_d = 4'd1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q < LAST_BIT) begin
            tx_d      = sh_q[0];
            sh_d      = sh_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (pen_q) begin
            tx_d    = par_bit_q;
            state_d = S_PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (!empty) begin
            pop        = 1'b1;
            sh_d       = head;
            pen_d      = parity_en;
            two_stop_d = two_stop;
            par_bit_d  = (^head) ^ parity_odd;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_serial_port_tx_gen.sv
module tb_serial_port_tx_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] phase;
  logic       change;
  logic       parity_en, parity_odd, two_stop;
  logic       baud_run;

  logic [7:0] tx_data8;
  logic       tx_dv8;
  logic       full8, empty8, overflow8, busy8, tx8;
  logic [5:0] level8;

  logic [4:0] tx_data5;
  logic       tx_dv5;
  logic       full5, empty5, overflow5, busy5, tx5;
  logic [5:0] level5;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  serial_port_tx_gen #(.DATA_BITS(8), .FIFO_DEPTH(32)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .phase(phase), .change(change),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tx_data(tx_data8), .tx_dv(tx_dv8), .full(full8), .empty(empty8),
    .overflow(overflow8), .level(level8), .busy(busy8), .tx(tx8)
  );

  serial_port_tx_gen #(.DATA_BITS(5), .FIFO_DEPTH(32)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .phase(phase), .change(change),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tx_data(tx_data5), .tx_dv(tx_dv5), .full(full5), .empty(empty5),
    .overflow(overflow5), .level(level5), .busy(busy5), .tx(tx5)
  );

  // Baud source: phase advances every 4 clk, tick every 16 clk.
  initial begin
    logic [3:0] c;
    c = '0;
    phase = 2'd1;
    change = 1'b0;
    forever begin
      @(negedge clk);
      c = c + 4'd1;
      phase = c[3:2];
      change = (c[1:0] == 2'd0) && baud_run;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns #1 after the next clock edge at which tick is seen by the DUT.
  task automatic wait_tick();
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(posedge clk);
      n++;
      got = (phase == 2'd0) && change;
    end
    if (!got) begin
      checks++;
      $error("FAIL tick_timeout: observed no tick expected tick within 64 cycles");
    end
    #1;
  endtask

  task automatic wr8(input logic [7:0] d);
    @(negedge clk);
    tx_data8 = d;
    tx_dv8 = 1'b1;
    @(negedge clk);
    tx_dv8 = 1'b0;
  endtask

  task automatic wr5(input logic [4:0] d);
    @(negedge clk);
    tx_data5 = d;
    tx_dv5 = 1'b1;
    @(negedge clk);
    tx_dv5 = 1'b0;
  endtask

  // bits: line values in transmission order, one character per bit period.
  task automatic check_frame(input string tag, input string bits, input bit five);
    for (int i = 0; i < bits.len(); i++) begin
      wait_tick();
      chk(tag, five ? tx5 : tx8, bits.getc(i) == "1");
      chk({tag, "_busy"}, five ? busy5 : busy8, 1);
    end
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0;
    baud_run = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    tx_data8 = '0;
    tx_dv8 = 1'b0;
    tx_data5 = '0;
    tx_dv5 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_full", full8, 0);
    chk("rst_empty", empty8, 1);
    chk("rst_overflow", overflow8, 0);
    chk("rst_level", level8, 0);
    chk("rst_tx5", tx5, 1);
    rst_n = 1'b1;

    // 8N1 frame 0xA5
    wait_tick();
    wr8(8'hA5);
    chk("8n1_busy_pre", busy8, 0);
    chk("8n1_level", level8, 1);
    check_frame("8n1", "0101001011", 1'b0);
    wait_tick();
    chk("8n1_busy_end", busy8, 0);
    chk("8n1_tx_idle", tx8, 1);

    // Even parity 0x07
    parity_en = 1'b1;
    parity_odd = 1'b0;
    wait_tick();
    wr8(8'h07);
    check_frame("8e1", "01110000011", 1'b0);
    wait_tick();
    chk("8e1_busy_end", busy8, 0);

    // Odd parity 0x07
    parity_odd = 1'b1;
    wait_tick();
    wr8(8'h07);
    check_frame("8o1", "01110000001", 1'b0);
    wait_tick();
    chk("8o1_busy_end", busy8, 0);

    // Two stop bits, back-to-back 0x55, 0xAA
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b1;
    wait_tick();
    wr8(8'h55);
    wr8(8'hAA);
    check_frame("8n2", "0101010101100101010111", 1'b0);
    wait_tick();
    chk("8n2_busy_end", busy8, 0);
    chk("8n2_tx_idle", tx8, 1);
    two_stop = 1'b0;

    // FIFO full and overflow, FSM stalled
    baud_run = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 33; i++) begin
      tx_data8 = 8'(i);
      tx_dv8 = 1'b1;
      if (i == 32) begin
        chk("ff_full", full8, 1);
        chk("ff_level", level8, 32);
        chk("ff_no_ovf_yet", overflow8, 0);
      end
      @(negedge clk);
    end
    tx_dv8 = 1'b0;
    chk("ff_overflow_pulse", overflow8, 1);
    chk("ff_level_after_drop", level8, 32);
    @(negedge clk);
    chk("ff_overflow_clear", overflow8, 0);
    chk("ff_still_full", full8, 1);
    baud_run = 1'b1;
    for (int k = 0; k < 32; k++) begin
      wait_tick();
      chk("ff_start", tx8, 0);
      w = '0;
      for (int b = 0; b < 8; b++) begin
        wait_tick();
        w[b] = tx8;
      end
      wait_tick();
      chk("ff_stop", tx8, 1);
      chk("ff_word", w, k);
    end
    wait_tick();
    chk("ff_drained_busy", busy8, 0);
    chk("ff_drained_empty", empty8, 1);

    // DATA_BITS = 5, parity_en changed mid-frame
    parity_en = 1'b0;
    wait_tick();
    wr5(5'h13);
    wait_tick();
    chk("w5_start", tx5, 0);
    parity_en = 1'b1;
    wr5(5'h0B);
    check_frame("w5", "11001101101011", 1'b1);
    wait_tick();
    chk("w5_busy_end", busy5, 0);
    chk("w5_tx_idle", tx5, 1);
    parity_en = 1'b0;

    // Reset during data bit 3 with 4 words queued
    wait_tick();
    for (int i = 0; i < 5; i++) wr8(8'hF0 + 8'(i));
    check_frame("rstm", "00000", 1'b0);
    chk("rstm_level_pre", level8, 4);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstm_tx", tx8, 1);
    chk("rstm_busy", busy8, 0);
    chk("rstm_empty", empty8, 1);
    chk("rstm_level", level8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_tick();
      chk("rstm_quiet_tx", tx8, 1);
    end
    chk("rstm_quiet_busy", busy8, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
